// File: rtl/regfile_wr_arbiter.sv
// Single write-port controller for the register file: round-robin arbitration
// between ALU (A) and load (B) writebacks, plus a command-driven clear sweep.
module regfile_wr_arbiter #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ReqA_valid,
    input  logic [D-1:0] ReqA_addr,
    input  logic [W-1:0] ReqA_data,
    input  logic         ReqA_zero,
    input  logic         ReqA_done,
    output logic         ReqA_ready,
    input  logic         ReqB_valid,
    input  logic [D-1:0] ReqB_addr,
    input  logic [W-1:0] ReqB_data,
    input  logic         ReqB_zero,
    input  logic         ReqB_done,
    output logic         ReqB_ready,
    input  logic         ClearStart,
    output logic         Busy,
    output logic         WrEn,
    output logic [D-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         WrZero,
    output logic         WrDone,
    output logic [7:0]   StallCnt
);
    typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

    localparam logic         PRIO_A   = 1'b0;
    localparam logic         PRIO_B   = 1'b1;
    localparam logic [D-1:0] CNT_LAST = {D{1'b1}};
    localparam logic [D-1:0] CNT_ONE  = {{(D-1){1'b0}}, 1'b1};

    state_t       state_r, state_s;
    logic [D-1:0] cnt_r, cnt_s;
    logic         prio_r, prio_s;
    logic         ready_a_s, ready_b_s, grant_a_s, grant_b_s, stall_s;
    logic         busy_r;
    logic         wr_en_r, wr_en_s;
    logic [D-1:0] wr_addr_r, wr_addr_s;
    logic [W-1:0] wr_data_r, wr_data_s;
    logic         wr_zero_r, wr_zero_s;
    logic         wr_done_r, wr_done_s;
    logic [7:0]   stall_cnt_r, stall_cnt_s;

    // Handshake readiness; held low while reset is asserted or a clear is pending/running.
    always_comb begin
        ready_a_s = 1'b0;
        ready_b_s = 1'b0;
        if (Reset && (state_r == ST_ARB) && !ClearStart) begin
            ready_a_s = !ReqB_valid || (prio_r == PRIO_A);
            ready_b_s = !ReqA_valid || (prio_r == PRIO_B);
        end else begin
            ready_a_s = 1'b0;
            ready_b_s = 1'b0;
        end
    end

    assign grant_a_s = ReqA_valid && ready_a_s;
    assign grant_b_s = ReqB_valid && ready_b_s;
    assign stall_s   = (ReqA_valid && !ready_a_s) || (ReqB_valid && !ready_b_s);

    // Next-state, priority pointer and write-port payload selection.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        prio_s    = prio_r;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        wr_zero_s = wr_zero_r;
        wr_done_s = wr_done_r;
        case (state_r)
            ST_ARB: begin
                if (ClearStart) begin
                    state_s = ST_CLEAR;
                    cnt_s   = {D{1'b0}};
                end else if (grant_a_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = ReqA_addr;
                    wr_data_s = ReqA_data;
                    wr_zero_s = ReqA_zero;
                    wr_done_s = ReqA_done;
                    prio_s    = PRIO_B;
                end else if (grant_b_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = ReqB_addr;
                    wr_data_s = ReqB_data;
                    wr_zero_s = ReqB_zero;
                    wr_done_s = ReqB_done;
                    prio_s    = PRIO_A;
                end else begin
                    state_s = ST_ARB;
                end
            end
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = cnt_r;
                wr_data_s = {W{1'b0}};
                wr_zero_s = 1'b0;
                wr_done_s = 1'b0;
                cnt_s     = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            default: begin
                state_s = ST_ARB;
                cnt_s   = {D{1'b0}};
            end
        endcase
    end

    // Saturating stall counter increment.
    always_comb begin
        stall_cnt_s = stall_cnt_r;
        if (stall_s && (stall_cnt_r != 8'hFF)) begin
            stall_cnt_s = stall_cnt_r + 8'd1;
        end else begin
            stall_cnt_s = stall_cnt_r;
        end
    end

    // State and registered write-port outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r     <= ST_ARB;
            cnt_r       <= {D{1'b0}};
            prio_r      <= PRIO_A;
            busy_r      <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= {D{1'b0}};
            wr_data_r   <= {W{1'b0}};
            wr_zero_r   <= 1'b0;
            wr_done_r   <= 1'b0;
            stall_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            prio_r      <= prio_s;
            busy_r      <= (state_s == ST_CLEAR);
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            wr_zero_r   <= wr_zero_s;
            wr_done_r   <= wr_done_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

    assign ReqA_ready = ready_a_s;
    assign ReqB_ready = ready_b_s;
    assign Busy       = busy_r;
    assign WrEn       = wr_en_r;
    assign WrAddr     = wr_addr_r;
    assign WrData     = wr_data_r;
    assign WrZero     = wr_zero_r;
    assign WrDone     = wr_done_r;
    assign StallCnt   = stall_cnt_r;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: vector table for arbitration, hand sequences for
// clear/reset/saturation, and a cycle-stamped scoreboard for every write-port update.
module tb_regfile_wr_arbiter;
    localparam int W = 8;
    localparam int D = 4;
    localparam int NREG = 16;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         ReqA_valid = 1'b0, ReqA_zero = 1'b0, ReqA_done = 1'b0;
    logic [D-1:0] ReqA_addr = '0;
    logic [W-1:0] ReqA_data = '0;
    logic         ReqB_valid = 1'b0, ReqB_zero = 1'b0, ReqB_done = 1'b0;
    logic [D-1:0] ReqB_addr = '0;
    logic [W-1:0] ReqB_data = '0;
    logic         ClearStart = 1'b0;
    logic         ReqA_ready, ReqB_ready, Busy, WrEn, WrZero, WrDone;
    logic [D-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic [7:0]   StallCnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [D-1:0] addr;
        logic [W-1:0] data;
        logic         zero;
        logic         done;
        int           due;
    } wr_t;
    wr_t sb[$];
    wr_t sb_e;

    typedef struct {
        logic av; logic [D-1:0] aa; logic [W-1:0] ad; logic az; logic adn;
        logic bv; logic [D-1:0] ba; logic [W-1:0] bd; logic bz; logic bdn;
        logic clr; logic exp_ra; logic exp_rb;
    } vec_t;
    vec_t vt[7];

    regfile_wr_arbiter #(.W(W), .D(D)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqA_valid(ReqA_valid), .ReqA_addr(ReqA_addr), .ReqA_data(ReqA_data),
        .ReqA_zero(ReqA_zero), .ReqA_done(ReqA_done), .ReqA_ready(ReqA_ready),
        .ReqB_valid(ReqB_valid), .ReqB_addr(ReqB_addr), .ReqB_data(ReqB_data),
        .ReqB_zero(ReqB_zero), .ReqB_done(ReqB_done), .ReqB_ready(ReqB_ready),
        .ClearStart(ClearStart), .Busy(Busy), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .WrZero(WrZero), .WrDone(WrDone), .StallCnt(StallCnt)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [D-1:0] a, input logic [W-1:0] d, input logic z,
                        input logic dn, input int due);
        wr_t e;
        e.addr = a; e.data = d; e.zero = z; e.done = dn; e.due = due;
        sb.push_back(e);
    endtask

    task automatic push_sweep(input int first_due);
        for (int i = 0; i < NREG; i++) push(4'(i), 8'h00, 1'b0, 1'b0, first_due + i);
    endtask

    task automatic set_idle();
        ReqA_valid = 1'b0; ReqB_valid = 1'b0; ClearStart = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge Clk);
        set_idle();
        Reset = 1'b0;
        sb.delete();
        @(negedge Clk);
        Reset = 1'b1;
        next_cycle();
    endtask

    task automatic apply_vec(input vec_t v);
        ReqA_valid = v.av; ReqA_addr = v.aa; ReqA_data = v.ad; ReqA_zero = v.az; ReqA_done = v.adn;
        ReqB_valid = v.bv; ReqB_addr = v.ba; ReqB_data = v.bd; ReqB_zero = v.bz; ReqB_done = v.bdn;
        ClearStart = v.clr;
    endtask

    // Both requesters always valid from a fresh reset: grants must alternate A,B,...
    task automatic contend(input int n);
        int na, nb, exp_stall;
        logic exp_a;
        na = 0; nb = 0;
        for (int k = 0; k < n; k++) begin
            ReqA_valid = 1'b1; ReqA_addr = 4'(8 + (na % 8)); ReqA_data = 8'(8'hA0 + na);
            ReqA_zero = na[0]; ReqA_done = ~na[0];
            ReqB_valid = 1'b1; ReqB_addr = 4'(nb % 8); ReqB_data = 8'(8'h30 + nb);
            ReqB_zero = ~nb[0]; ReqB_done = nb[0];
            @(negedge Clk);
            exp_a = ((k % 2) == 0);
            exp_stall = (k > 255) ? 255 : k;
            check("cont_ready_a", ReqA_ready, exp_a);
            check("cont_ready_b", ReqB_ready, !exp_a);
            check("cont_stall", StallCnt, exp_stall);
            if (exp_a) begin
                push(ReqA_addr, ReqA_data, ReqA_zero, ReqA_done, cyc + 1);
                na++;
            end else begin
                push(ReqB_addr, ReqB_data, ReqB_zero, ReqB_done, cyc + 1);
                nb++;
            end
            next_cycle();
        end
        set_idle();
    endtask

    // Scoreboard: every write-port update must match the oldest expectation due this cycle.
    always @(negedge Clk) begin
        if (Reset) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL sb_missed: write to %0h due cycle %0d never seen (cycle %0d)",
                         sb[0].addr, sb[0].due, cyc);
                sb_e = sb.pop_front();
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                sb_e = sb.pop_front();
                check("wr_en", WrEn, 1'b1);
                check("wr_addr", WrAddr, sb_e.addr);
                check("wr_data", WrData, sb_e.data);
                check("wr_zero", WrZero, sb_e.zero);
                check("wr_done", WrDone, sb_e.done);
            end else begin
                check("wr_idle", WrEn, 1'b0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected under 20000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1'b1, 4'd3, 8'h5A, 1'b0, 1'b1,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1};
        vt[2] = '{1'b1, 4'd1, 8'h11, 1'b1, 1'b0,  1'b1, 4'd2, 8'h22, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 4'd1, 8'h11, 1'b1, 1'b0,  1'b1, 4'd4, 8'h44, 1'b1, 1'b1,  1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0,  1'b1, 4'd5, 8'h55, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1};
        vt[5] = '{1'b0, 4'd0, 8'h00, 1'b0, 1'b0,  1'b1, 4'd6, 8'h66, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b1, 4'd7, 8'h77, 1'b1, 1'b1,  1'b0, 4'd0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0};

        // Reset state, with both requesters asserting valid
        ReqA_valid = 1'b1; ReqB_valid = 1'b1;
        #2;
        check("rst_wr_en", WrEn, 1'b0);
        check("rst_wr_addr", WrAddr, 4'd0);
        check("rst_wr_data", WrData, 8'd0);
        check("rst_wr_flags", {WrZero, WrDone}, 2'b00);
        check("rst_busy", Busy, 1'b0);
        check("rst_stall", StallCnt, 8'd0);
        check("rst_ready_a", ReqA_ready, 1'b0);
        check("rst_ready_b", ReqB_ready, 1'b0);
        set_idle();
        @(negedge Clk);
        Reset = 1'b1;
        next_cycle();

        // Table-driven arbitration
        for (int i = 0; i < 7; i++) begin
            apply_vec(vt[i]);
            @(negedge Clk);
            check("tbl_ready_a", ReqA_ready, vt[i].exp_ra);
            check("tbl_ready_b", ReqB_ready, vt[i].exp_rb);
            if (vt[i].av && vt[i].exp_ra) push(vt[i].aa, vt[i].ad, vt[i].az, vt[i].adn, cyc + 1);
            if (vt[i].bv && vt[i].exp_rb) push(vt[i].ba, vt[i].bd, vt[i].bz, vt[i].bdn, cyc + 1);
            next_cycle();
        end
        set_idle();
        @(negedge Clk);
        check("tbl_stall", StallCnt, 8'd2);
        next_cycle();

        // Contention from reset
        reset_dut();
        contend(8);

        // Single-cycle clear with A waiting
        for (int k = 0; k <= 18; k++) begin
            ClearStart = (k == 0);
            ReqA_valid = (k <= 17); ReqA_addr = 4'hC; ReqA_data = 8'hC3;
            ReqA_zero = 1'b0; ReqA_done = 1'b1;
            @(negedge Clk);
            if (k == 0) push_sweep(cyc + 2);
            if (k <= 17) begin
                check("clr_busy", Busy, (k >= 1 && k <= 16));
                check("clr_ready_a", ReqA_ready, (k == 17));
            end
            if (k == 17) begin
                check("clr_stall", StallCnt, 8'd25);
                push(4'hC, 8'hC3, 1'b0, 1'b1, cyc + 1);
            end
            next_cycle();
        end
        set_idle();

        // ClearStart held across a whole sweep re-triggers once back in ARB
        for (int k = 0; k <= 35; k++) begin
            ClearStart = (k <= 20);
            @(negedge Clk);
            if (k == 0 || k == 17) push_sweep(cyc + 2);
            check("retrig_busy", Busy, ((k >= 1 && k <= 16) || (k >= 18 && k <= 33)));
            check("retrig_ready_a", ReqA_ready, (k >= 34));
            check("retrig_ready_b", ReqB_ready, (k >= 34));
            next_cycle();
        end
        set_idle();

        // Reset after sweep address 7
        for (int k = 0; k <= 9; k++) begin
            ClearStart = (k == 0);
            @(negedge Clk);
            if (k == 0) push_sweep(cyc + 2);
            if (k < 9) next_cycle();
        end
        #1;
        Reset = 1'b0;
        sb.delete();
        ClearStart = 1'b0;
        ReqB_valid = 1'b1; ReqB_addr = 4'd9; ReqB_data = 8'h99; ReqB_zero = 1'b1; ReqB_done = 1'b1;
        #1;
        check("mid_rst_wr_en", WrEn, 1'b0);
        check("mid_rst_wr_addr", WrAddr, 4'd0);
        check("mid_rst_wr_data", {WrZero, WrDone, WrData}, 10'd0);
        check("mid_rst_busy", Busy, 1'b0);
        check("mid_rst_ready_b", ReqB_ready, 1'b0);
        @(negedge Clk);
        check("mid_rst_held_busy", Busy, 1'b0);
        check("mid_rst_held_stall", StallCnt, 8'd0);
        Reset = 1'b1;
        #1;
        check("post_rst_ready_b", ReqB_ready, 1'b1);
        push(4'd9, 8'h99, 1'b1, 1'b1, cyc + 1);
        next_cycle();
        set_idle();
        @(negedge Clk);
        check("post_rst_busy", Busy, 1'b0);
        check("post_rst_stall", StallCnt, 8'd0);
        next_cycle();

        // Stall counter saturation
        reset_dut();
        contend(300);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("sat_hold", StallCnt, 8'd255);
            next_cycle();
        end
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        check("sat_rst_clear", StallCnt, 8'd0);
        @(negedge Clk);
        Reset = 1'b1;
        next_cycle();

        repeat (3) next_cycle();
        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port controller in front of the register file. Arbitrates the file's single write port between two requesters: A (ALU writeback) and B (load/memory writeback). Uses round-robin priority with a valid/ready handshake. Also runs a clear sequence on command, sweeping every register and both flags to zero. All write-port outputs are registered, so the register file sees one clean write per cycle.

## Interface
Parameters:
- W, 8, data path width
- D, 4, register address width (2**D registers)

Ports:
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset (asserted when 0)
- ReqA_valid  in  1  requester A has a write pending
- ReqA_addr  in  D  A target register
- ReqA_data  in  W  A write data
- ReqA_zero, ReqA_done  in  1 each  A flag values to store
- ReqA_ready  out  1  A transfer accepted this cycle (when valid)
- ReqB_valid, ReqB_addr, ReqB_data, ReqB_zero, ReqB_done, ReqB_ready  same as A, for requester B
- ClearStart  in  1  request a full register/flag clear
- Busy  out  1  clear sequence in progress
- WrEn  out  1  register file write enable
- WrAddr  out  D  register file write address
- WrData  out  W  register file write data
- WrZero, WrDone  out  1 each  flag values to the register file
- StallCnt  out  8  saturating count of stall cycles

## Operation
- States: ARB (reset state) and CLEAR.
- A transfer occurs when ReqX_valid && ReqX_ready in the same cycle.
- Requesters hold valid and payload stable until accepted.
- ARB readiness (combinational):
  - ReqA_ready = !ClearStart && (!ReqB_valid || prio==A)
  - ReqB_ready = !ClearStart && (!ReqA_valid || prio==B)
- Ready may be high while valid is low.
- At most one transfer per cycle.
- Priority pointer:
  - reset value A;
  - after a grant to A it becomes B, after a grant to B it becomes A;
  - unchanged on cycles with no grant.
- On a transfer, the next edge loads WrEn=1 and WrAddr/WrData/WrZero/WrDone from the winner. With no transfer, WrEn=0 and the other Wr* outputs hold their values.
- ClearStart in ARB:
  - both readies are 0 that cycle, so clear wins over same-cycle requests;
  - the next edge enters CLEAR with sweep counter cnt=0.
- CLEAR:
  - both readies are 0;
  - each edge loads WrEn=1, WrAddr=cnt, WrData=0, WrZero=0, WrDone=0 and increments cnt;
  - on the edge registering cnt==2**D-1, return to ARB.
- ClearStart while in CLEAR is ignored and does not restart the sweep.
- Busy = (state==CLEAR).
- StallCnt:
  - +1 on every cycle where (ReqA_valid && !ReqA_ready) || (ReqB_valid && !ReqB_ready), including CLEAR cycles;
  - at most +1 per cycle;
  - saturates at 255;
  - cleared only by reset.

## Timing
- Request latency: accepted in cycle n -> WrEn=1 with payload in cycle n+1 -> register file updates at the end of n+1.
- Back-to-back: one write per cycle sustained. With both requesters continuously valid, grants alternate A,B,A,B...
- Clear: ClearStart in cycle n.
  - CLEAR occupies cycles n+1..n+2**D (Busy=1).
  - Write outputs present addresses 0..2**D-1 in cycles n+2..n+2**D+1.
  - ARB resumes in cycle n+2**D+1.
  - The first post-clear request accepted there appears in cycle n+2**D+2.
  - No overlap with sweep writes.
- Reset (asynchronous, any state including mid-clear) forces immediately:
  - state=ARB, cnt=0, prio=A;
  - WrEn=0, WrAddr=0, WrData=0, WrZero=0, WrDone=0;
  - Busy=0, StallCnt=0;
  - both readies 0 while Reset is low.
- On Reset deassertion, ARB operation begins at the first rising edge.
- A partially completed sweep is abandoned and not resumed.

## Test plan
- Single requester: A valid, addr=3, data=0x5A, zero=0, done=1, B idle -> ReqA_ready=1 same cycle; next cycle WrEn=1, WrAddr=3, WrData=0x5A, WrDone=1; following cycle WrEn=0.
- Contention: A and B valid continuously from reset with distinct addrs -> grants A,B,A,B; StallCnt increments by 1 every cycle.
- Clear: ClearStart for one cycle with A also valid -> A not accepted; Busy=1 for 16 cycles; WrEn=1 with WrAddr 0..15, data 0, flags 0; A accepted in the first cycle after Busy falls.
- Clear re-trigger: ClearStart held high through the whole sweep -> exactly 16 sweep writes, then a new sweep starts (ARB sees ClearStart) with readies 0 throughout.
- Reset mid-clear: assert Reset after sweep address 7 -> all outputs 0 immediately, Busy=0; after release, a B request is granted with prio=A semantics and WrEn occurs one cycle later.
- Saturation: hold B valid through 300 clear-blocked or contended cycles -> StallCnt stops at 255 and stays there until reset.
